mem_load_stage: RTL and testbench

- Memory-response stage directly downstream of the execute stage.
- Accepts one dcache request per handshake from EX and tracks it until dcache returns data_ok.
- Aligns and sign/zero-extends load data, then presents a registered one-cycle writeback pulse to the WB/commit side.
- Drives a stall to ctrl while a response is outstanding, and discards responses belonging to flushed instructions.

---
 rtl/mem_load_stage.sv | 146 ++++++++++++++
 tb/tb_mem_load_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_stage.sv
// Memory-response stage: tracks one outstanding dcache request from EX, aligns and
// extends the returned load data, and emits a registered one-cycle writeback pulse.
module mem_load_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_load_type,
    input  logic [1:0]        ex_addr_lo,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic              flush,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] wb_pc,
    output logic              pause_mem
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                is_load_q;
    logic [2:0]          load_type_q;
    logic [1:0]          addr_lo_q;
    logic [RD_W-1:0]     rd_q;
    logic [DATA_W-1:0]   pc_q;

    logic                wb_valid_q;
    logic                wb_we_q;
    logic [RD_W-1:0]     wb_rd_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic [DATA_W-1:0]   wb_pc_q;

    logic                capture;
    logic                complete;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic [DATA_W-1:0]   load_result;
    logic [DATA_W-1:0]   wb_data_d;

    // A response arriving together with a flush belongs to a squashed instruction.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && !flush) begin
                    state_d = S_WAIT;
                    capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    state_d  = S_IDLE;
                    complete = !flush;
                end else if (flush) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pause_mem = ((state_q == S_WAIT) && !data_ok) ||
                       (state_q == S_DISCARD) ||
                       ((state_q == S_IDLE) && ex_valid && !flush);

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? rdata[31:16] : rdata[15:0];

        load_result = rdata;
        case (load_type_q)
            3'd0:    load_result = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_result = {24'h000000, byte_sel};
            3'd2:    load_result = {{16{half_sel[15]}}, half_sel};
            3'd3:    load_result = {16'h0000, half_sel};
            default: load_result = rdata;
        endcase

        wb_data_d = is_load_q ? load_result : '0;
    end

    // Writeback fields only move on a completion so they hold between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            is_load_q   <= 1'b0;
            load_type_q <= '0;
            addr_lo_q   <= '0;
            rd_q        <= '0;
            pc_q        <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_pc_q     <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= complete;
            if (capture) begin
                is_load_q   <= ex_is_load;
                load_type_q <= ex_load_type;
                addr_lo_q   <= ex_addr_lo;
                rd_q        <= ex_rd;
                pc_q        <= ex_pc;
            end
            if (complete) begin
                wb_we_q   <= is_load_q && (rd_q != '0);
                wb_rd_q   <= rd_q;
                wb_data_q <= wb_data_d;
                wb_pc_q   <= pc_q;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_pc    = wb_pc_q;

endmodule

// File: tb/tb_mem_load_stage.sv
// Bench for mem_load_stage: directed vector table plus random transactions
// checked against a behavioural load-extension model.
module tb_mem_load_stage;

    typedef struct {
        logic        isLoad;
        logic [2:0]  loadType;
        logic [1:0]  addrLo;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] rdata;
        int          delay;
        int          mode;
        logic        expWe;
        logic [31:0] expData;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid, exIsLoad, flush, dataOk;
    logic [2:0]  exLoadType;
    logic [1:0]  exAddrLo;
    logic [4:0]  exRd;
    logic [31:0] exPc, rdata;
    logic        wbValid, wbWe, pauseMem;
    logic [4:0]  wbRd;
    logic [31:0] wbData, wbPc;

    int          total = 0;
    int          bad = 0;
    logic [4:0]  lastRd = '0;
    logic [31:0] lastData = '0;
    logic [31:0] lastPc = '0;
    txn_t        vec[12];

    mem_load_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(exValid), .ex_is_load(exIsLoad), .ex_load_type(exLoadType),
        .ex_addr_lo(exAddrLo), .ex_rd(exRd), .ex_pc(exPc),
        .flush(flush), .data_ok(dataOk), .rdata(rdata),
        .wb_valid(wbValid), .wb_we(wbWe), .wb_rd(wbRd), .wb_data(wbData),
        .wb_pc(wbPc), .pause_mem(pauseMem)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick the addressed byte/half arithmetically, then extend.
    function automatic logic [31:0] refData(input logic isLoad, input logic [2:0] lt,
                                            input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (!isLoad) return 32'h0;
        case ((lt > 3'd4) ? 3'd4 : lt)
            3'd0: begin v = (w >> (8 * a)) & 32'hFF;   return (v >= 32'h80)   ? (v | 32'hFFFFFF00) : v; end
            3'd1: return (w >> (8 * a)) & 32'hFF;
            3'd2: begin v = (w >> (16 * a[1])) & 32'hFFFF; return (v >= 32'h8000) ? (v | 32'hFFFF0000) : v; end
            3'd3: return (w >> (16 * a[1])) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // mode 0: normal, 1: flush then DISCARD, 2: flush with data_ok, 3: flush at accept
    task automatic applyStimulus(input txn_t t);
        exValid    = 1'b1;
        exIsLoad   = t.isLoad;
        exLoadType = t.loadType;
        exAddrLo   = t.addrLo;
        exRd       = t.rd;
        exPc       = t.pc;
        flush      = (t.mode == 3);
        #1 checkOutput("pause_accept", {31'b0, pauseMem}, {31'b0, t.mode != 3});
        tick();
        exValid = 1'b0;
        flush   = 1'b0;
        checkOutput("wb_valid_busy", {31'b0, wbValid}, 32'h0);
        if (t.mode == 3) begin
            checkOutput("pause_ignored", {31'b0, pauseMem}, 32'h0);
            return;
        end
        if (t.mode == 0) begin
            for (int i = 0; i < t.delay - 1; i++) begin
                checkOutput("pause_wait", {31'b0, pauseMem}, 32'h1);
                tick();
            end
            dataOk = 1'b1;
            rdata  = t.rdata;
            #1 checkOutput("pause_dataok", {31'b0, pauseMem}, 32'h0);
            tick();
            dataOk = 1'b0;
            rdata  = $urandom;
            checkOutput("wb_valid", {31'b0, wbValid}, 32'h1);
            checkOutput("wb_we", {31'b0, wbWe}, {31'b0, t.expWe});
            checkOutput("wb_data", wbData, t.expData);
            checkOutput("wb_rd", {27'b0, wbRd}, {27'b0, t.rd});
            checkOutput("wb_pc", wbPc, t.pc);
            lastRd = t.rd; lastData = t.expData; lastPc = t.pc;
            tick();
            checkOutput("wb_valid_pulse", {31'b0, wbValid}, 32'h0);
            checkOutput("wb_data_hold", wbData, lastData);
        end else if (t.mode == 1) begin
            flush = 1'b1;
            #1 checkOutput("pause_flush", {31'b0, pauseMem}, 32'h1);
            tick();
            flush = 1'b0;
            for (int i = 0; i < t.delay; i++) begin
                flush = 1'($urandom_range(0, 1));
                #1 checkOutput("pause_discard", {31'b0, pauseMem}, 32'h1);
                tick();
            end
            flush  = 1'b0;
            dataOk = 1'b1;
            rdata  = t.rdata;
            #1 checkOutput("pause_discard_ok", {31'b0, pauseMem}, 32'h1);
            tick();
            dataOk = 1'b0;
            checkOutput("wb_valid_dropped", {31'b0, wbValid}, 32'h0);
            checkOutput("wb_data_dropped_hold", wbData, lastData);
            checkOutput("pause_after_discard", {31'b0, pauseMem}, 32'h0);
        end else begin
            flush  = 1'b1;
            dataOk = 1'b1;
            rdata  = t.rdata;
            #1 checkOutput("pause_flush_ok", {31'b0, pauseMem}, 32'h0);
            tick();
            flush  = 1'b0;
            dataOk = 1'b0;
            checkOutput("wb_valid_flushok", {31'b0, wbValid}, 32'h0);
            checkOutput("wb_pc_hold", wbPc, lastPc);
            checkOutput("wb_rd_hold", {27'b0, wbRd}, {27'b0, lastRd});
            checkOutput("pause_idle", {31'b0, pauseMem}, 32'h0);
        end
    endtask

    initial begin
        txn_t r;
        rst = 1'b0; exValid = 0; exIsLoad = 0; exLoadType = 0; exAddrLo = 0;
        exRd = 0; exPc = 0; flush = 0; dataOk = 0; rdata = 0;
        #2;
        checkOutput("rst_wb_valid", {31'b0, wbValid}, 32'h0);
        checkOutput("rst_wb_data", wbData, 32'h0);
        checkOutput("rst_pause", {31'b0, pauseMem}, 32'h0);
        @(negedge clk); rst = 1'b1;
        tick();

        vec[0]  = '{1'b1, 3'd0, 2'd3, 5'd5,  32'h1000, 32'h80FF1234, 3, 0, 1'b1, 32'hFFFFFF80};
        vec[1]  = '{1'b1, 3'd3, 2'd2, 5'd6,  32'h1004, 32'h80017FFF, 2, 0, 1'b1, 32'h00008001};
        vec[2]  = '{1'b1, 3'd2, 2'd0, 5'd8,  32'h1008, 32'h80017FFF, 1, 0, 1'b1, 32'h00007FFF};
        vec[3]  = '{1'b0, 3'd4, 2'd0, 5'd4,  32'h100C, 32'hDEADBEEF, 1, 0, 1'b0, 32'h00000000};
        vec[4]  = '{1'b1, 3'd4, 2'd0, 5'd9,  32'h1010, 32'hAAAA5555, 2, 1, 1'b1, 32'h0};
        vec[5]  = '{1'b1, 3'd4, 2'd0, 5'd7,  32'h1014, 32'h12345678, 2, 0, 1'b1, 32'h12345678};
        vec[6]  = '{1'b1, 3'd4, 2'd0, 5'd10, 32'h1018, 32'h55555555, 1, 2, 1'b1, 32'h0};
        vec[7]  = '{1'b1, 3'd4, 2'd0, 5'd0,  32'h101C, 32'hCAFEF00D, 1, 0, 1'b0, 32'hCAFEF00D};
        vec[8]  = '{1'b1, 3'd1, 2'd1, 5'd11, 32'h1020, 32'h00008A00, 1, 0, 1'b1, 32'h0000008A};
        vec[9]  = '{1'b1, 3'd0, 2'd1, 5'd12, 32'h1024, 32'h00008A00, 2, 0, 1'b1, 32'hFFFFFF8A};
        vec[10] = '{1'b1, 3'd6, 2'd0, 5'd13, 32'h1028, 32'h87654321, 1, 0, 1'b1, 32'h87654321};
        vec[11] = '{1'b1, 3'd4, 2'd0, 5'd14, 32'h102C, 32'h11111111, 1, 3, 1'b1, 32'h0};

        for (int i = 0; i < 12; i++) applyStimulus(vec[i]);

        for (int i = 0; i < 40; i++) begin
            r.isLoad   = 1'($urandom_range(0, 3) != 0);
            r.loadType = 3'($urandom_range(0, 7));
            r.addrLo   = 2'($urandom_range(0, 3));
            if (r.loadType == 3'd2 || r.loadType == 3'd3) r.addrLo[0] = 1'b0;
            if (r.loadType >= 3'd4) r.addrLo = 2'd0;
            r.rd      = 5'($urandom_range(0, 31));
            r.pc      = $urandom & 32'hFFFFFFFC;
            r.rdata   = $urandom;
            r.delay   = $urandom_range(1, 4);
            r.mode    = ($urandom_range(0, 5) < 4) ? 0 : $urandom_range(1, 3);
            r.expWe   = r.isLoad && (r.rd != 5'd0);
            r.expData = refData(r.isLoad, r.loadType, r.addrLo, r.rdata);
            applyStimulus(r);
        end

        // Asynchronous reset while a response is outstanding.
        exValid = 1'b1; exIsLoad = 1'b1; exLoadType = 3'd4; exAddrLo = 2'd0;
        exRd = 5'd3; exPc = 32'h2000;
        tick();
        exValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_pause", {31'b0, pauseMem}, 32'h0);
        checkOutput("arst_wb_valid", {31'b0, wbValid}, 32'h0);
        checkOutput("arst_wb_data", wbData, 32'h0);
        checkOutput("arst_wb_pc", wbPc, 32'h0);
        checkOutput("arst_wb_rd", {27'b0, wbRd}, 32'h0);
        @(negedge clk); rst = 1'b1;
        tick();
        dataOk = 1'b1; rdata = 32'h99999999;
        #1 checkOutput("late_ok_pause", {31'b0, pauseMem}, 32'h0);
        tick();
        dataOk = 1'b0;
        checkOutput("late_ok_wb_valid", {31'b0, wbValid}, 32'h0);
        checkOutput("late_ok_wb_data", wbData, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
